// File: rtl/dec_sequencer.sv
// dec_sequencer: countdown controller that steps a count register through an
// external combinational decrementer (DEC). It can optionally auto-reload,
// which turns it into a periodic timer.
module dec_sequencer #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] load_val,
  input  logic                 auto_reload,
  input  logic                 en,
  input  logic                 abort,
  output logic [DATAWIDTH-1:0] dec_a,
  input  logic [DATAWIDTH-1:0] dec_d,
  output logic [DATAWIDTH-1:0] count,
  output logic                 busy,
  output logic                 tick,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [DATAWIDTH-1:0] count_nxt;
  logic [DATAWIDTH-1:0] reload_val;
  logic                 reload_en;
  logic                 capture;
  logic                 tick_nxt;

  // The decrementer always sees the live count, so dec_d is ready before each edge.
  assign dec_a = count;
  assign busy  = (state != IDLE);

  // Next-state and next-count selection; the decrement comes only from dec_d.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tick_nxt  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (load_val != '0) begin
            count_nxt = load_val;
            state_nxt = RUN;
          end else begin
            count_nxt = '0;
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (en) begin
          count_nxt = dec_d;
          tick_nxt  = 1'b1;
          // Leaving at count==1 guarantees the count never decrements from 0.
          if (count == DATAWIDTH'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (reload_en && (reload_val != '0)) begin
          count_nxt = reload_val;
          state_nxt = RUN;
        end else if (reload_en) begin
          // A zero reload value parks here and pulses done every cycle.
          count_nxt = '0;
          state_nxt = DONE;
        end else begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, count and the registered tick/done pulses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      count <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tick  <= tick_nxt;
      done  <= (state_nxt == DONE);
    end
  end

  // Reload settings are captured only when a start is accepted.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      reload_val <= '0;
      reload_en  <= 1'b0;
    end else if (capture) begin
      reload_val <= load_val;
      reload_en  <= auto_reload;
    end
  end

endmodule

// File: doc/dec_sequencer.md
# dec_sequencer

Countdown controller that sequences a shared combinational `DEC` datapath unit. On `start` it loads a value, steps it down through the external `DEC` instance once per enabled cycle, and signals completion when the count reaches zero. An optional auto-reload mode makes it a periodic timer. It sits beside a `DEC` instance: it drives the decrementer's `a` input and registers its `d` output.

## Interface
- `DATAWIDTH`, default 8: width of count, load value and `DEC` operands.

- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: reset, asynchronous, active-low.
- `start` in 1: load request, sampled only in IDLE.
- `load_val` in DATAWIDTH: start count, captured when `start` is accepted.
- `auto_reload` in 1: captured with `start`. When 1, the block restarts from the captured value after each completion.
- `en` in 1: step enable in RUN.
- `abort` in 1: cancels RUN or DONE.
- `dec_a` out DATAWIDTH: operand to `DEC.a`, equal to the `count` register at all times.
- `dec_d` in DATAWIDTH: result from `DEC.d`, expected as `dec_a - 1` combinationally.
- `count` out DATAWIDTH: current count register.
- `busy` out 1: 1 in RUN and DONE.
- `tick` out 1: registered pulse, 1 for the one cycle after each decrement edge.
- `done` out 1: registered one-cycle completion pulse.

## Operation
- State machine: IDLE, RUN, DONE.
- Holding registers:
  - `count`.
  - `reload_val`, captured from `load_val` on start.
  - `reload_en`, captured from `auto_reload` on start.
- **IDLE:**
  - `start`=1 and `load_val`≠0: `count`←`load_val`, go to RUN.
  - `start`=1 and `load_val`=0: `count`←0, go straight to DONE. No decrement and no `tick`.
  - Otherwise hold state and `count`.
- **RUN**, in priority order:
  1. `abort`=1: `count`←0, go to IDLE. No `done`, no `tick`.
  2. `en`=1: `count`←`dec_d` and `tick`←1. If `count`=1, go to DONE.
  3. `en`=0: hold. `tick`←0.
  - `start` is ignored in RUN.
- **DONE:**
  - `done`=1 for exactly this one cycle.
  - `abort`=1: go to IDLE, `count`←0. `done` still shows 1 for this cycle.
  - `reload_en`=1 and `reload_val`≠0: `count`←`reload_val`, go to RUN.
  - `reload_en`=1 and `reload_val`=0: stay in DONE with `count`=0. `done` then pulses every cycle until `abort` or reset.
  - Otherwise go to IDLE. `count` stays 0.
  - `start` is ignored in DONE.
- Arithmetic:
  - All values are unsigned, modulo 2^DATAWIDTH.
  - `count` never decrements from 0, because reaching 0 always leaves RUN. The wrap value (all ones) is therefore unreachable by decrement.
  - `load_val` = 2^DATAWIDTH−1 is legal and takes that many steps.
- The block never computes the decrement itself. The next `count` comes only from `dec_d`.

## Timing
- Reset (`Rst`=0, asynchronous):
  - State goes to IDLE.
  - `count`, `dec_a`, `busy`, `tick` and `done` all go to 0.
  - `reload_val` and `reload_en` go to 0.
  - The first active edge after `Rst` rises is treated as normal IDLE operation.
- Start acceptance: `start` high at edge k (with `load_val`=N≠0). After edge k: `busy`=1, `count`=N.
- Stepping: with `en` held high, `count` reaches 0 after edge k+N.
  - DONE (`done`=1, `busy`=1) is held during the cycle between edges k+N and k+N+1.
  - After edge k+N+1: IDLE with `busy`=0, or RUN with `count`=N under reload.
  - Start-to-done latency is N+1 edges plus one per cycle where `en`=0.
- Zero load: `start` at edge k puts the block in DONE after edge k, and in IDLE after edge k+1.
- `tick`: high in the cycle after each edge where RUN and `en`=1 and `abort`=0. In that cycle `count` shows the new value. The last `tick` coincides with `done`.
- Auto-reload period: N+1 cycles per loop with `en` constant high. `done` pulses once per period.
- Back-to-back: `start` can be accepted at the edge that leaves DONE for IDLE only one edge later. The earliest restart is therefore 1 idle cycle after `done`.
- `dec_a` follows `count` combinationally, so `dec_d` must be stable before each edge. `DEC` is combinational with zero cycles.

## Test plan
- Basic run: reset, `load_val`=3, `start` for 1 cycle, `en`=1 held.
  - Required: `count` reads 3, 2, 1, 0 on consecutive cycles.
  - Required: `tick` is high on the 2, 1, 0 cycles; `done` is high only on the 0 cycle; `busy` drops the cycle after.
- Enable gaps: `load_val`=2, with `en` pattern 1, 0, 0, 1.
  - Required: `count` holds at 1 for two cycles with `tick`=0; `done` comes 2 cycles late.
  - Required: `start` pulsed mid-RUN has no effect.
- Zero and max load:
  - `load_val`=0: `done` one cycle after `start`, no `tick`, `count`=0 throughout.
  - DATAWIDTH=8, `load_val`=255: `done` after 256 edges; `count` never shows 255 after the load.
- Abort: `load_val`=5, `abort` asserted when `count`=3.
  - Required: next cycle IDLE, `count`=0, `busy`=0, no `done` ever.
- Auto-reload: `load_val`=2, `auto_reload`=1, `en`=1.
  - Required: `done` every 3 cycles and `count` sequence 2, 1, 0, 2, 1, 0.
  - Then `abort` during DONE: `done` is seen for that cycle, then IDLE.
- Reset mid-run: drop `Rst` asynchronously while `count`=4.
  - Required: all outputs go to 0 immediately, not at the clock.
  - Required: after release, `start` with `load_val`=1 gives a normal 1-step run.
